// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC sequencing, IF/ID output register, stall buffer and redirect drain.
// Optional macro IF_FETCH_PERF_CNT_EN adds a delivered-instruction counter output fetch_cnt.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] PCadd4,
    output logic        addr_err
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pcadd4_q, pcadd4_d;
    logic        valid_q, valid_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;

    // Requests are suppressed while reset is held so the first request follows deassertion.
    assign imem_req  = !reset && (state_q != HOLD);
    assign imem_addr = pc_q;
    assign valid_out = valid_q;
    assign instr     = instr_q;
    assign pc_out    = pc_out_q;
    assign PCadd4    = pcadd4_q;
    assign addr_err  = addr_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            pc_out_q    <= 32'h0;
            pcadd4_q    <= 32'h0;
            valid_q     <= 1'b0;
            addr_err_q  <= 1'b0;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= 32'h0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            pcadd4_q    <= pcadd4_d;
            valid_q     <= valid_d;
            addr_err_q  <= addr_err_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        pcadd4_d    = pcadd4_q;
        valid_d     = valid_q;
        addr_err_d  = 1'b0;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;

        if (redirect_valid) begin
            pc_d        = {redirect_pc[31:2], 2'b00};
            valid_d     = 1'b0;
            buf_valid_d = 1'b0;
            addr_err_d  = |redirect_pc[1:0];
            unique case (state_q)
                // An outstanding request with no response yet must be drained first.
                FETCH:   state_d = imem_ready ? FETCH : DRAIN;
                HOLD:    state_d = FETCH;
                DRAIN:   state_d = imem_ready ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_q + 32'd4;
                        if (stall) begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc_q;
                            buf_valid_d = 1'b1;
                            state_d     = HOLD;
                        end else begin
                            instr_d  = imem_rdata;
                            pc_out_d = pc_q;
                            pcadd4_d = pc_q + 32'd4;
                            valid_d  = 1'b1;
                        end
                    end else if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d     = buf_instr_q;
                        pc_out_d    = buf_pc_q;
                        pcadd4_d    = buf_pc_q + 32'd4;
                        valid_d     = buf_valid_q;
                        buf_valid_d = 1'b0;
                        state_d     = FETCH;
                    end
                end
                DRAIN: begin
                    // The response arriving here belongs to the abandoned address.
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic        deliver;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    assign deliver = !redirect_valid && !stall &&
                     (((state_q == FETCH) && imem_ready) || ((state_q == HOLD) && buf_valid_q));
    assign fetch_cnt_d = deliver ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    assign fetch_cnt   = fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end
`endif

endmodule
